// File: rtl/bsr_meta_pkg.sv
// Shared types and default widths for the BSR metadata walker.
package bsr_meta_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned DEFAULT_IDX_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRdP0,
    StRdPtr,
    StWaitPtr,
    StRdCol,
    StWaitCol,
    StEmit,
    StDone
  } walk_state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrPtrDec   = 2'd1,
    ErrColRange = 2'd2
  } err_code_e;

endpackage

// File: rtl/bsr_row_walker_if.sv
// Metadata-cache read port and block output handshake of the row walker.
interface bsr_row_walker_if
  import bsr_meta_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned IDX_W  = DEFAULT_IDX_W
);
  logic [ADDR_W-1:0] meta_raddr;
  logic              meta_ren;
  logic [31:0]       meta_rdata;
  logic              meta_rvalid;

  logic [IDX_W-1:0]  blk_row;
  logic [IDX_W-1:0]  blk_col;
  logic [31:0]       blk_idx;
  logic              blk_last_in_row;
  logic              blk_last;
  logic              blk_valid;
  logic              blk_ready;

  modport master (
    output meta_raddr, meta_ren,
    input  meta_rdata, meta_rvalid,
    output blk_row, blk_col, blk_idx, blk_last_in_row, blk_last, blk_valid,
    input  blk_ready
  );

  modport slave (
    input  meta_raddr, meta_ren,
    output meta_rdata, meta_rvalid,
    input  blk_row, blk_col, blk_idx, blk_last_in_row, blk_last, blk_valid,
    output blk_ready
  );
endinterface

// File: rtl/bsr_row_walker.sv
// Walks BSR row_ptr/col_idx metadata from a small cache and emits one
// handshaked record per nonzero block, with range and monotonicity checks.
module bsr_row_walker
  import bsr_meta_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned IDX_W  = DEFAULT_IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       cfg_num_block_rows,
  input  logic [15:0]       cfg_num_block_cols,
  input  logic [ADDR_W-1:0] cfg_rowptr_base,
  input  logic [ADDR_W-1:0] cfg_colidx_base,
  bsr_row_walker_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  walk_state_e       state_q, state_d;
  logic              p0_wait_q, p0_wait_d;
  logic [15:0]       rows_q, rows_d;
  logic [15:0]       cols_q, cols_d;
  logic [ADDR_W-1:0] rp_base_q, rp_base_d;
  logic [ADDR_W-1:0] ci_base_q, ci_base_d;
  logic [15:0]       r_q, r_d;
  logic [31:0]       k_q, k_d;
  logic [31:0]       ptr_lo_q, ptr_lo_d;
  logic [31:0]       ptr_hi_q, ptr_hi_d;
  logic [15:0]       col_q, col_d;
  logic              err_q, err_d;
  err_code_e         err_code_q, err_code_d;

  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic              emit;
  logic              next_row;
  logic [15:0]       col_sel;

  always_comb begin
    state_d    = state_q;
    p0_wait_d  = p0_wait_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    rp_base_d  = rp_base_q;
    ci_base_d  = ci_base_q;
    r_d        = r_q;
    k_d        = k_q;
    ptr_lo_d   = ptr_lo_q;
    ptr_hi_d   = ptr_hi_q;
    col_d      = col_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    ren        = 1'b0;
    raddr      = '0;
    emit       = 1'b0;
    next_row   = 1'b0;
    col_sel    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d      = 1'b0;
          err_code_d = ErrNone;
          rows_d     = cfg_num_block_rows;
          cols_d     = cfg_num_block_cols;
          rp_base_d  = cfg_rowptr_base;
          ci_base_d  = cfg_colidx_base;
          r_d        = '0;
          p0_wait_d  = 1'b0;
          state_d    = (cfg_num_block_rows == 16'd0) ? StDone : StRdP0;
        end
      end
      StRdP0: begin
        // First cycle issues the read, following cycle collects row_ptr[0].
        if (!p0_wait_q) begin
          ren       = 1'b1;
          raddr     = rp_base_q;
          p0_wait_d = 1'b1;
        end else if (bus.meta_rvalid) begin
          ptr_lo_d  = bus.meta_rdata;
          p0_wait_d = 1'b0;
          state_d   = StRdPtr;
        end
      end
      StRdPtr: begin
        ren     = 1'b1;
        raddr   = rp_base_q + ADDR_W'(r_q) + ADDR_W'(1);
        state_d = StWaitPtr;
      end
      StWaitPtr: begin
        if (bus.meta_rvalid) begin
          ptr_hi_d = bus.meta_rdata;
          if (bus.meta_rdata < ptr_lo_q) begin
            err_d      = 1'b1;
            err_code_d = ErrPtrDec;
            state_d    = StDone;
          end else if (bus.meta_rdata == ptr_lo_q) begin
            next_row = 1'b1;
          end else begin
            k_d     = ptr_lo_q;
            state_d = StRdCol;
          end
        end
      end
      StRdCol: begin
        ren     = 1'b1;
        raddr   = ci_base_q + ADDR_W'(k_q >> 1);
        state_d = StWaitCol;
      end
      StWaitCol: begin
        if (bus.meta_rvalid) begin
          // Two 16-bit column indices are packed per cache word.
          col_sel = k_q[0] ? bus.meta_rdata[31:16] : bus.meta_rdata[15:0];
          if (col_sel >= cols_q) begin
            err_d      = 1'b1;
            err_code_d = ErrColRange;
            state_d    = StDone;
          end else begin
            col_d   = col_sel;
            state_d = StEmit;
          end
        end
      end
      StEmit: begin
        emit = 1'b1;
        if (bus.blk_ready) begin
          if ((k_q + 32'd1) < ptr_hi_q) begin
            k_d     = k_q + 32'd1;
            state_d = StRdCol;
          end else begin
            next_row = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (next_row) begin
      ptr_lo_d = ptr_hi_d;
      r_d      = r_q + 16'd1;
      state_d  = ((r_q + 16'd1) == rows_q) ? StDone : StRdPtr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      p0_wait_q  <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      rp_base_q  <= '0;
      ci_base_q  <= '0;
      r_q        <= '0;
      k_q        <= '0;
      ptr_lo_q   <= '0;
      ptr_hi_q   <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      p0_wait_q  <= p0_wait_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      rp_base_q  <= rp_base_d;
      ci_base_q  <= ci_base_d;
      r_q        <= r_d;
      k_q        <= k_d;
      ptr_lo_q   <= ptr_lo_d;
      ptr_hi_q   <= ptr_hi_d;
      col_q      <= col_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Block fields come straight from registers that only change on transfer.
  always_comb begin
    bus.meta_ren        = ren;
    bus.meta_raddr      = raddr;
    bus.blk_valid       = emit;
    bus.blk_row         = emit ? IDX_W'(r_q) : '0;
    bus.blk_col         = emit ? IDX_W'(col_q) : '0;
    bus.blk_idx         = emit ? k_q : '0;
    bus.blk_last_in_row = emit && (k_q == (ptr_hi_q - 32'd1));
    bus.blk_last        = emit && (k_q == (ptr_hi_q - 32'd1)) &&
                          (r_q == (rows_q - 16'd1));
    busy                = (state_q != StIdle);
    done                = (state_q == StDone);
    err                 = err_q;
    err_code            = err_code_q;
  end

endmodule

// File: tb/tb_bsr_row_walker.sv
// Scoreboard bench for bsr_row_walker: a walk model fills read/block/end queues,
// a negedge monitor pops and compares against the DUT.
module tb_bsr_row_walker;
  import bsr_meta_pkg::*;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [31:0] idx;
    logic        lir;
    logic        last;
  } blk_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_rows = '0;
  logic [15:0] cfg_cols = '0;
  logic [7:0]  cfg_rpb = '0;
  logic [7:0]  cfg_cib = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;

  bsr_row_walker_if #(.ADDR_W(8), .IDX_W(16)) bus ();

  bsr_row_walker #(.ADDR_W(8), .IDX_W(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .cfg_num_block_rows (cfg_rows),
    .cfg_num_block_cols (cfg_cols),
    .cfg_rowptr_base    (cfg_rpb),
    .cfg_colidx_base    (cfg_cib),
    .bus                (bus),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .err_code           (err_code)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [7:0]  exp_reads [$];
  blk_t        exp_blk [$];
  logic [1:0]  exp_end [$];
  int          ncmp = 0;
  int          nerr = 0;
  int          ready_mode = 0;
  int          stall_cnt = 0;
  int          tmo_req = 0;
  int          tmo_seen = 0;

  // Cache: data returns exactly one cycle after the request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.meta_rvalid <= 1'b0;
      bus.meta_rdata  <= '0;
    end else begin
      bus.meta_rvalid <= bus.meta_ren;
      bus.meta_rdata  <= mem[bus.meta_raddr];
    end
  end

  // Consumer: 0 always ready, 1 random, 2 stall the first block 5 cycles, 3 never ready.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: bus.blk_ready = 1'($urandom_range(0, 1));
      2: begin
        if (bus.blk_valid && stall_cnt < 5) begin
          bus.blk_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.blk_ready = 1'b1;
        end
      end
      3: bus.blk_ready = 1'b0;
      default: bus.blk_ready = 1'b1;
    endcase
    if (ready_mode != 2) stall_cnt = 0;
  end

  always @(negedge clk) begin : mon
    blk_t       cur, e_b;
    blk_t       snap;
    logic       stalled, prev_ren, prev_done, prev_rst;
    logic [7:0] a;
    logic [1:0] e;
    cur = {bus.blk_row, bus.blk_col, bus.blk_idx, bus.blk_last_in_row, bus.blk_last};
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      ncmp++;
      nerr++;
      $display("FAIL walk_timeout: got no done/blk_valid, required one within budget");
    end
    if (!rst_n) begin
      if (prev_rst) begin
        ncmp++;
        if (exp_reads.size() != 0) begin
          nerr++;
          $display("FAIL reads_before_reset: got %0d pending, required 0", exp_reads.size());
        end
      end
      ncmp++;
      if ({busy, done, err, err_code, bus.meta_ren, bus.meta_raddr, bus.blk_valid, cur} !== '0) begin
        nerr++;
        $display("FAIL reset_outputs: got busy=%b done=%b err=%b code=%0d ren=%b addr=%h valid=%b blk=%h, required all 0",
                 busy, done, err, err_code, bus.meta_ren, bus.meta_raddr, bus.blk_valid, cur);
      end
      exp_reads.delete();
      exp_blk.delete();
      exp_end.delete();
      stalled = 1'b0;
      prev_ren = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.meta_ren) begin
        ncmp++;
        if (exp_reads.size() == 0) begin
          nerr++;
          $display("FAIL read_addr: got unexpected read at %h, required none", bus.meta_raddr);
        end else begin
          a = exp_reads.pop_front();
          if (bus.meta_raddr !== a) begin
            nerr++;
            $display("FAIL read_addr: got %h, required %h", bus.meta_raddr, a);
          end
        end
        ncmp++;
        if (prev_ren) begin
          nerr++;
          $display("FAIL read_outstanding: got ren on consecutive cycles, required one outstanding");
        end
      end
      if (stalled) begin
        ncmp++;
        if (!(bus.blk_valid && cur == snap)) begin
          nerr++;
          $display("FAIL blk_stable: got valid=%b blk=%h, required valid=1 blk=%h",
                   bus.blk_valid, cur, snap);
        end
      end
      if (bus.blk_valid) begin
        ncmp++;
        if (bus.meta_ren) begin
          nerr++;
          $display("FAIL ren_in_emit: got ren=1 while blk_valid, required 0");
        end
      end
      if (bus.blk_valid && bus.blk_ready) begin
        ncmp++;
        if (exp_blk.size() == 0) begin
          nerr++;
          $display("FAIL blk: got unexpected block %h, required none", cur);
        end else begin
          e_b = exp_blk.pop_front();
          if (cur !== e_b) begin
            nerr++;
            $display("FAIL blk: got row=%0d col=%0d idx=%0d lir=%b last=%b, required row=%0d col=%0d idx=%0d lir=%b last=%b",
                     cur.row, cur.col, cur.idx, cur.lir, cur.last,
                     e_b.row, e_b.col, e_b.idx, e_b.lir, e_b.last);
          end
        end
      end
      stalled = bus.blk_valid && !bus.blk_ready;
      snap = cur;
      if (prev_done) begin
        ncmp++;
        if (done) begin
          nerr++;
          $display("FAIL done_width: got done=1 for 2 cycles, required 1");
        end
      end
      if (done) begin
        ncmp++;
        if (exp_end.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_done: got done=1, required 0");
        end else begin
          e = exp_end.pop_front();
          if ({err, err_code, busy} !== {(e != 2'd0), e, 1'b1}) begin
            nerr++;
            $display("FAIL end_status: got err=%b code=%0d busy=%b, required err=%b code=%0d busy=1",
                     err, err_code, busy, (e != 2'd0), e);
          end
          ncmp++;
          if (exp_reads.size() != 0 || exp_blk.size() != 0) begin
            nerr++;
            $display("FAIL end_drain: got %0d reads and %0d blocks missing, required 0 and 0",
                     exp_reads.size(), exp_blk.size());
          end
        end
      end else if (exp_end.size() == 0) begin
        ncmp++;
        if (busy) begin
          nerr++;
          $display("FAIL idle_busy: got busy=1, required 0");
        end
      end
      prev_ren = bus.meta_ren;
      prev_done = done;
    end
    prev_rst = rst_n;
  end

  task automatic set_col(input logic [7:0] cib, input logic [31:0] k, input logic [15:0] v);
    logic [7:0] a;
    a = cib + 8'(k >> 1);
    if (k[0]) mem[a][31:16] = v;
    else mem[a][15:0] = v;
  endtask

  // Walk derived directly from the row_ptr/col_idx rules.
  task automatic model_walk(input int unsigned R, input int unsigned C,
                            input logic [7:0] rpb, input logic [7:0] cib);
    logic [31:0] lo, hi, w;
    logic [7:0]  a;
    logic [15:0] col;
    logic [1:0]  ecode;
    ecode = 2'd0;
    lo = '0;
    if (R != 0) begin
      exp_reads.push_back(rpb);
      lo = mem[rpb];
      for (int unsigned r = 0; r < R && ecode == 2'd0; r++) begin
        a = rpb + 8'(r + 1);
        exp_reads.push_back(a);
        hi = mem[a];
        if (hi < lo) begin
          ecode = 2'd1;
        end else begin
          for (logic [31:0] k = lo; k < hi && ecode == 2'd0; k++) begin
            a = cib + 8'(k >> 1);
            exp_reads.push_back(a);
            w = mem[a];
            col = k[0] ? w[31:16] : w[15:0];
            if (32'(col) >= C) ecode = 2'd2;
            else exp_blk.push_back({16'(r), col, k, (k == hi - 1),
                                    (k == hi - 1) && (r == R - 1)});
          end
          lo = hi;
        end
      end
    end
    exp_end.push_back(ecode);
  endtask

  task automatic kick(input int unsigned R, input int unsigned C,
                      input logic [7:0] rpb, input logic [7:0] cib);
    @(posedge clk); #1;
    cfg_rows = 16'(R);
    cfg_cols = 16'(C);
    cfg_rpb  = rpb;
    cfg_cib  = cib;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_walk(input int unsigned R, input int unsigned C,
                          input logic [7:0] rpb, input logic [7:0] cib, input int mode);
    int cyc;
    model_walk(R, C, rpb, cib);
    ready_mode = mode;
    kick(R, C, rpb, cib);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) tmo_req++;
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    int          cyc;
    int unsigned R, C;
    logic [7:0]  rpb, cib;
    logic [31:0] p, pn;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Two rows, three blocks, always ready.
    mem[8'h10] = 0; mem[8'h11] = 2; mem[8'h12] = 3;
    set_col(8'h20, 0, 16'd1); set_col(8'h20, 1, 16'd3); set_col(8'h20, 2, 16'd0);
    run_walk(2, 4, 8'h10, 8'h20, 0);
    // Zero rows goes straight to done.
    run_walk(0, 4, 8'h10, 8'h20, 0);
    // Empty leading and trailing rows.
    mem[8'h30] = 0; mem[8'h31] = 0; mem[8'h32] = 1; mem[8'h33] = 1;
    set_col(8'h40, 0, 16'd2);
    run_walk(3, 4, 8'h30, 8'h40, 0);
    // Back-pressure on the first block.
    run_walk(2, 4, 8'h10, 8'h20, 2);
    // Decreasing row_ptr after three blocks.
    mem[8'h50] = 0; mem[8'h51] = 3; mem[8'h52] = 2;
    set_col(8'h60, 0, 16'd0); set_col(8'h60, 1, 16'd1); set_col(8'h60, 2, 16'd2);
    run_walk(2, 4, 8'h50, 8'h60, 0);
    // Column equal to the bound.
    mem[8'h70] = 0; mem[8'h71] = 1;
    set_col(8'h80, 0, 16'd4);
    run_walk(1, 4, 8'h70, 8'h80, 0);
    // Recovery from error with a clean walk.
    run_walk(2, 4, 8'h10, 8'h20, 1);

    for (int it = 0; it < 25; it++) begin
      R   = $urandom_range(1, 6);
      C   = $urandom_range(1, 40);
      rpb = 8'($urandom);
      cib = rpb + 8'd16;
      p   = $urandom_range(0, 3);
      mem[rpb] = p;
      for (int unsigned r = 0; r < R; r++) begin
        if ($urandom_range(0, 19) == 0 && p > 0) pn = p - 1;
        else pn = p + $urandom_range(0, 3);
        mem[rpb + 8'(r + 1)] = pn;
        for (logic [31:0] k = p; k < pn; k++) begin
          if ($urandom_range(0, 24) == 0) set_col(cib, k, 16'(C + $urandom_range(0, 3)));
          else set_col(cib, k, 16'($urandom_range(0, C - 1)));
        end
        p = pn;
      end
      run_walk(R, C, rpb, cib, ($urandom_range(0, 2) == 0) ? 0 : 1);
    end

    // Wrapping row_ptr addresses, then reset while a block is held.
    mem[8'hFE] = 0; mem[8'hFF] = 0; mem[8'h00] = 1;
    set_col(8'h40, 0, 16'd3);
    model_walk(2, 4, 8'hFE, 8'h40);
    ready_mode = 3;
    kick(2, 4, 8'hFE, 8'h40);
    cyc = 0;
    while (!bus.blk_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.blk_valid) tmo_req++;
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    ready_mode = 0;
    repeat (20) @(posedge clk);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bsr_row_walker.md
BSR_ROW_WALKER -- requirements
Module: bsr_row_walker

Interface
REQ-001 Parameter ADDR_W, default 8, metadata cache address width.
REQ-002 Parameter IDX_W, default 16, row/column block-index width.
REQ-003 clk  input  1  clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that begins a walk; ignored while busy.
REQ-006 cfg_num_block_rows  input  16  block rows to walk (R).
REQ-007 cfg_num_block_cols  input  16  column bound for range check.
REQ-008 cfg_rowptr_base  input  ADDR_W  cache address of row_ptr[0].
REQ-009 cfg_colidx_base  input  ADDR_W  cache address of first col_idx word.
REQ-010 meta_raddr  output  ADDR_W  cache read address.
REQ-011 meta_ren  output  1  cache read request.
REQ-012 meta_rdata  input  32  cache read data.
REQ-013 meta_rvalid  input  1  read data valid, exactly one cycle after meta_ren.
REQ-014 blk_row / blk_col  output  IDX_W each  block coordinates.
REQ-015 blk_idx  output  32  nonzero-block ordinal (row_ptr index k).
REQ-016 blk_last_in_row / blk_last  output  1 each  last block of row / of walk.
REQ-017 blk_valid  output  1; blk_ready  input  1  output handshake.
REQ-018 busy / done / err  output  1 each  walking / one-cycle completion pulse / sticky error.
REQ-019 err_code  output  2  0=none, 1=row_ptr decreasing, 2=column out of range.

Function
REQ-020 States: IDLE, RD_P0, RD_PTR, WAIT_PTR, RD_COL, WAIT_COL, EMIT, DONE.
REQ-021 IDLE: on start with R>0, clear err/err_code, latch cfg, r=0, go RD_P0; on start with R=0, go DONE directly.
REQ-022 RD_P0: issue ren at rowptr_base, capture rdata into ptr_lo on rvalid, go RD_PTR.
REQ-023 RD_PTR: issue ren at rowptr_base+r+1; WAIT_PTR captures ptr_hi.
REQ-024 WAIT_PTR: ptr_hi<ptr_lo -> err=1, err_code=1, go DONE; ptr_hi==ptr_lo (empty row) -> next row; else k=ptr_lo, go RD_COL.
REQ-025 RD_COL: issue ren at colidx_base+(k>>1); WAIT_COL selects rdata[15:0] when k[0]=0, rdata[31:16] when k[0]=1.
REQ-026 Column >= cfg_num_block_cols -> err=1, err_code=2, go DONE, no block emitted.
REQ-027 EMIT: blk_valid=1 with blk_row=r, blk_col, blk_idx=k; blk_last_in_row=(k==ptr_hi-1); blk_last=blk_last_in_row and r==R-1.
REQ-028 While blk_valid && !blk_ready, all blk_* outputs remain stable; transfer occurs on blk_valid && blk_ready.
REQ-029 After transfer: k+1<ptr_hi -> RD_COL with k+1; else next row.
REQ-030 Next row: ptr_lo=ptr_hi, r=r+1; r==R -> DONE; else RD_PTR.
REQ-031 DONE: done=1 for one cycle, go IDLE; busy=1 in every state except IDLE.
REQ-032 Address sums wrap modulo 2^ADDR_W; k and ptr arithmetic are 32-bit unsigned.
REQ-033 meta_ren is high exactly one cycle per read; at most one read outstanding.
REQ-034 Trailing empty rows: blk_last is not asserted and the walk ends via DONE.
REQ-035 err holds until next accepted start.

Reset
REQ-036 Asynchronous rst_n low: state=IDLE; all outputs 0, including busy, done, blk_valid, meta_ren, err, and err_code.
REQ-037 Reset mid-walk abandons the walk; no done pulse is produced after release.

Structure
REQ-038 A shared package, bsr_meta_pkg, holds the state enum, the err_code enum, and the default widths ADDR_W and IDX_W.
REQ-039 The block is single-module, with no sub-module.

Verification
REQ-040 R=2, row_ptr={0,2,3}, col={1,3,0}, ready=1 -> blocks (0,1,k0), (0,3,k1,last_in_row), (1,0,k2,last), then done.
REQ-041 R=3, row_ptr={0,0,1,1}, col={2} -> single block (1,2,k0), blk_last=0, then done.
REQ-042 blk_ready low for 5 cycles during the first block -> outputs stable, no additional meta_ren issued.
REQ-043 row_ptr={0,3,2} -> three row-0 blocks, then err=1, err_code=1, done.
REQ-044 cfg_num_block_cols=4, col idx 4 at k=0 -> err_code=2, no blk_valid.
REQ-045 rowptr_base=8'hFE, R=2 -> reads at FE, FF, 00; rst_n pulse mid-EMIT -> all outputs 0 immediately.
